shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 84 ++++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Shift sequencer: arbitrates parallel loads of two shift registers and,
// on an Execute request, issues exactly N_SHIFTS consecutive shift enables,
// then holds Done until Execute is released.
module shift_sequencer #(
  parameter int unsigned N_SHIFTS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic       Execute,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Count
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(N_SHIFTS);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;

  // State and shift-count registers; reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and count update; Count is only cleared when a new run starts,
  // so the final value stays visible through HOLD and the following IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (Execute) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        count_d = count_q + 4'd1;
        if (count_d == LAST_COUNT) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!Execute) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output decode: run status from registered state only; load enables are
  // granted in IDLE unless Execute claims the same cycle.
  always_comb begin
    Shift_En = (state_q == SHIFT);
    Busy     = (state_q == SHIFT);
    Done     = (state_q == HOLD);
    Ld_A     = LoadA && (state_q == IDLE) && !Execute;
    Ld_B     = LoadB && (state_q == IDLE) && !Execute;
  end

  assign Count = count_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: three instances (N_SHIFTS = 8, 1, 15)
// share clock, reset and load inputs; each has its own Execute. Expected run
// outcomes are queued by the stimulus and popped by a monitor on Done.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       load_a;
  logic       load_b;
  logic [2:0] exec;
  logic [2:0] lda, ldb, shen, busy, done;
  logic [3:0] cnt [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int inst;
    int shifts;
    int count;
    int hold;
  } exp_t;

  exp_t exp_q[$];

  shift_sequencer #(.N_SHIFTS(8)) u_n8 (
    .Clk(clk), .Reset(rst), .LoadA(load_a), .LoadB(load_b), .Execute(exec[0]),
    .Ld_A(lda[0]), .Ld_B(ldb[0]), .Shift_En(shen[0]), .Busy(busy[0]),
    .Done(done[0]), .Count(cnt[0])
  );

  shift_sequencer #(.N_SHIFTS(1)) u_n1 (
    .Clk(clk), .Reset(rst), .LoadA(load_a), .LoadB(load_b), .Execute(exec[1]),
    .Ld_A(lda[1]), .Ld_B(ldb[1]), .Shift_En(shen[1]), .Busy(busy[1]),
    .Done(done[1]), .Count(cnt[1])
  );

  shift_sequencer #(.N_SHIFTS(15)) u_n15 (
    .Clk(clk), .Reset(rst), .LoadA(load_a), .LoadB(load_b), .Execute(exec[2]),
    .Ld_A(lda[2]), .Ld_B(ldb[2]), .Shift_En(shen[2]), .Busy(busy[2]),
    .Done(done[2]), .Count(cnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input int inst, input int shifts, input int hold);
    exp_t e;
    e.inst   = inst;
    e.shifts = shifts;
    e.count  = shifts;
    e.hold   = hold;
    exp_q.push_back(e);
  endtask

  // Monitor: measures each run and compares against the scoreboard on Done.
  int   run_len  [3] = '{0, 0, 0};
  int   done_len [3] = '{0, 0, 0};
  int   exp_hold [3] = '{0, 0, 0};
  logic shen_p   [3] = '{1'b0, 1'b0, 1'b0};
  logic done_p   [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (shen[i] && !shen_p[i]) run_len[i] = 0;
      if (shen[i]) begin
        chk($sformatf("count_during_shift[%0d]", i), int'(cnt[i]), run_len[i]);
        chk($sformatf("busy_with_shift[%0d]", i), int'(busy[i]), 1);
        chk($sformatf("no_load_in_shift[%0d]", i), int'(lda[i] | ldb[i]), 0);
        run_len[i]++;
      end
      if (done[i] && !done_p[i]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 1, 0);
          exp_hold[i] = -1;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("done_instance[%0d]", i), i, e.inst);
          chk($sformatf("shift_cycles[%0d]", i), run_len[i], e.shifts);
          chk($sformatf("final_count[%0d]", i), int'(cnt[i]), e.count);
          exp_hold[i] = e.hold;
        end
        done_len[i] = 0;
      end
      if (done[i]) begin
        done_len[i]++;
        chk($sformatf("no_shift_in_hold[%0d]", i), int'(shen[i] | busy[i]), 0);
      end
      if (!done[i] && done_p[i] && exp_hold[i] >= 0)
        chk($sformatf("done_cycles[%0d]", i), done_len[i], exp_hold[i]);
      shen_p[i] = shen[i];
      done_p[i] = done[i];
    end
  end

  initial begin
    rst    = 1'b1;
    load_a = 1'b0;
    load_b = 1'b0;
    exec   = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_shift_en", int'(shen[0]), 0);
    chk("reset_busy",     int'(busy[0]), 0);
    chk("reset_done",     int'(done[0]), 0);
    chk("reset_count",    int'(cnt[0]),  0);
    tick();
    rst = 1'b0;
    tick();

    // Basic run: Execute pulsed for two edges.
    expect_run(0, 8, 1);
    exec[0] = 1'b1;
    repeat (2) tick();
    exec[0] = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("basic_idle_busy", int'(busy[0]), 0);
    chk("basic_idle_done", int'(done[0]), 0);
    chk("count_held_in_idle", int'(cnt[0]), 8);

    // Held Execute: 30 edges high -> 8 shifts, Done for the 22 HOLD cycles.
    expect_run(0, 8, 22);
    exec[0] = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("held_done_still_high", int'(done[0]), 1);
    exec[0] = 1'b0;
    repeat (5) tick();

    // Load arbitration.
    load_a = 1'b1;
    #1;
    chk("idle_lda", int'(lda[0]), 1);
    chk("idle_ldb_off", int'(ldb[0]), 0);
    load_b = 1'b1;
    #1;
    chk("both_lda", int'(lda[0]), 1);
    chk("both_ldb", int'(ldb[0]), 1);
    exec[0] = 1'b1;
    #1;
    chk("exec_blocks_lda", int'(lda[0]), 0);
    chk("exec_blocks_ldb", int'(ldb[0]), 0);
    expect_run(0, 8, 1);
    tick();
    load_a = 1'b0;
    tick();
    exec[0] = 1'b0;
    @(negedge clk);
    chk("shift_ldb_blocked", int'(ldb[0]), 0);
    chk("shift_active", int'(shen[0]), 1);
    repeat (10) tick();
    @(negedge clk);
    chk("idle_ldb_again", int'(ldb[0]), 1);
    load_b = 1'b0;
    tick();

    // Mid-run reset at Count=4.
    exec[0] = 1'b1;
    tick();
    exec[0] = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("midrun_count4", int'(cnt[0]), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_shift_en", int'(shen[0]), 0);
    chk("midrun_busy",     int'(busy[0]), 0);
    chk("midrun_done",     int'(done[0]), 0);
    chk("midrun_count",    int'(cnt[0]),  0);
    repeat (3) tick();

    // Execute held through reset starts a run right after release.
    rst     = 1'b1;
    exec[0] = 1'b1;
    tick();
    rst = 1'b0;
    expect_run(0, 8, 1);
    tick();
    exec[0] = 1'b0;
    @(negedge clk);
    chk("start_after_reset", int'(shen[0]), 1);
    repeat (12) tick();

    // Back-to-back runs.
    expect_run(0, 8, 1);
    expect_run(0, 8, 1);
    exec[0] = 1'b1;
    tick();
    exec[0] = 1'b0;
    repeat (10) tick();
    exec[0] = 1'b1;
    tick();
    exec[0] = 1'b0;
    @(negedge clk);
    chk("second_run_count_cleared", int'(cnt[0]), 0);
    repeat (12) tick();

    // Parameter sweep: N_SHIFTS = 1 and 15.
    expect_run(1, 1, 1);
    exec[1] = 1'b1;
    repeat (2) tick();
    exec[1] = 1'b0;
    repeat (5) tick();
    expect_run(2, 15, 1);
    exec[2] = 1'b1;
    repeat (2) tick();
    exec[2] = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("sweep_n1_count",  int'(cnt[1]), 1);
    chk("sweep_n15_count", int'(cnt[2]), 15);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
